// File: rtl/ones_csum_engine_pkg.sv
// Shared types and defaults for the ones' complement checksum engine.
// Imported by the interface, the step adder and the engine top.
package csum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FOLD,
        DONE
    } csum_state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNTW  = 16;

endpackage

// File: rtl/ones_csum_engine_if.sv
// Word-in / checksum-out stream bundle for ones_csum_engine.
// master drives words and consumes results; slave is the engine.
interface ones_csum_engine_if
    import csum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [WIDTH-1:0] out_csum;
    logic             out_neg_zero;
    logic [CNTW-1:0]  out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_csum,
        input  out_neg_zero, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_csum,
        output out_neg_zero, out_count
    );
endinterface

// File: rtl/ones_csum_engine_adder.sv
// Shared WIDTH-bit ripple adder with carry in/out, built from full adders.
// Each bit keeps its own carry net so the chain has no vector self-dependency.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module m1s_step_adder
    import csum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic ci;
            logic co;
            if (i == 0) begin : g_first
                assign ci = cin;
            end else begin : g_rest
                assign ci = g_bit[i-1].co;
            end
            full_adder u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .ci (ci),
                .s  (sum[i]),
                .co (co)
            );
        end
    endgenerate

    assign cout = g_bit[WIDTH-1].co;
endmodule

// File: rtl/ones_csum_engine.sv
// Sequential ones' complement checksum engine: registered end-around
// carry, re-injected on the next beat and folded in one final cycle.
module ones_csum_engine
    import csum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    ones_csum_engine_if.slave  bus
);
    csum_state_e      state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic             carry, carry_n;
    logic [CNTW-1:0]  cnt, cnt_n;

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;
    logic             beat;
    logic [CNTW-1:0]  cnt_inc;

    // FOLD only re-injects the carry; the word input is masked off
    assign op_b = (state == FOLD) ? '0 : bus.in_data;

    m1s_step_adder #(.WIDTH(WIDTH)) u_add (
        .a    (acc),
        .b    (op_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_co)
    );

    assign bus.in_ready     = (state == IDLE) || (state == ACCUM);
    assign bus.out_valid    = (state == DONE);
    assign bus.out_sum      = acc;
    assign bus.out_csum     = ~acc;
    assign bus.out_neg_zero = &acc;
    assign bus.out_count    = cnt;

    assign beat    = bus.in_valid && bus.in_ready && !flush;
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        carry_n = carry;
        cnt_n   = cnt;
        if (flush) begin
            state_n = IDLE;
            acc_n   = '0;
            carry_n = 1'b0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc_n   = add_sum;
                        carry_n = add_co;
                        cnt_n   = cnt_inc;
                        state_n = bus.in_last ? FOLD : ACCUM;
                    end
                end
                FOLD: begin
                    acc_n   = add_sum;
                    carry_n = add_co;
                    if (!add_co) state_n = DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_n = IDLE;
                        acc_n   = '0;
                        carry_n = 1'b0;
                        cnt_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            carry <= carry_n;
            cnt   <= cnt_n;
        end
    end

    // acc=all-ones with carry=1 cannot be reached, so one fold always suffices
    a_fold_once: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == FOLD && !flush) |=> (state != FOLD)
    );
endmodule

// File: tb/tb_ones_csum_engine.sv
// Directed self-checking bench for ones_csum_engine.
// Two instances: default widths, and CNTW=2 for counter saturation.
module tb_ones_csum_engine;
    import csum_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    logic flush2;
    int   checks;
    int   errors;

    ones_csum_engine_if #(.WIDTH(16), .CNTW(16)) bus ();
    ones_csum_engine_if #(.WIDTH(16), .CNTW(2))  bus2 ();

    ones_csum_engine #(.WIDTH(16), .CNTW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    ones_csum_engine #(.WIDTH(16), .CNTW(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush2),
        .bus   (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, bus.out_valid}, 32'd1);
    endtask

    initial begin
        logic [15:0] ip [10];
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        flush2 = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.in_last   = 1'b0;
        bus2.out_ready = 1'b1;

        // reset values
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_sum", {16'd0, bus.out_sum}, 32'h0000);
        chk("rst_out_csum", {16'd0, bus.out_csum}, 32'hFFFF);
        chk("rst_neg_zero", {31'd0, bus.out_neg_zero}, 32'd0);
        chk("rst_out_count", {16'd0, bus.out_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // carry-free packet with exact latency
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b1);
        chk("t1_fold_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t1_fold_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("t1_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_done_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t1_sum", {16'd0, bus.out_sum}, 32'h0003);
        chk("t1_csum", {16'd0, bus.out_csum}, 32'hFFFC);
        chk("t1_count", {16'd0, bus.out_count}, 32'd2);
        @(negedge clk);
        chk("t1_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t1_idle_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t1_idle_count", {16'd0, bus.out_count}, 32'd0);

        // end-around carry
        push(16'hFFFF, 1'b0);
        push(16'h0001, 1'b1);
        wait_valid("t2_valid");
        chk("t2_sum", {16'd0, bus.out_sum}, 32'h0001);
        chk("t2_csum", {16'd0, bus.out_csum}, 32'hFFFE);
        chk("t2_neg_zero", {31'd0, bus.out_neg_zero}, 32'd0);
        @(negedge clk);

        // IPv4 header with random source gaps
        ip = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
               16'h0000, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push(ip[k], k == 9);
        end
        wait_valid("t3_valid");
        chk("t3_sum", {16'd0, bus.out_sum}, 32'h479E);
        chk("t3_csum", {16'd0, bus.out_csum}, 32'hB861);
        chk("t3_count", {16'd0, bus.out_count}, 32'd10);
        @(negedge clk);

        // output backpressure, negative zero
        bus.out_ready = 1'b0;
        push(16'hFFFF, 1'b1);
        wait_valid("t4_valid");
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("t4_hold_sum", {16'd0, bus.out_sum}, 32'hFFFF);
            chk("t4_hold_csum", {16'd0, bus.out_csum}, 32'h0000);
            chk("t4_hold_negz", {31'd0, bus.out_neg_zero}, 32'd1);
            chk("t4_hold_ready", {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t4_release_ready", {31'd0, bus.in_ready}, 32'd1);
        push(16'h1234, 1'b1);
        wait_valid("t4b_valid");
        chk("t4b_sum", {16'd0, bus.out_sum}, 32'h1234);
        @(negedge clk);

        // flush with the third beat, which must be dropped
        push(16'h8000, 1'b0);
        push(16'h8000, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h8000;
        flush        = 1'b1;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_flush_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t5_flush_count", {16'd0, bus.out_count}, 32'd0);
        chk("t5_flush_valid", {31'd0, bus.out_valid}, 32'd0);
        push(16'h0005, 1'b1);
        wait_valid("t5_valid");
        chk("t5_sum", {16'd0, bus.out_sum}, 32'h0005);
        chk("t5_count", {16'd0, bus.out_count}, 32'd1);
        @(negedge clk);

        // flush in DONE wins over out_ready
        bus.out_ready = 1'b0;
        push(16'h0007, 1'b1);
        wait_valid("t5b_valid");
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t5b_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("t5b_count", {16'd0, bus.out_count}, 32'd0);

        // asynchronous reset while in FOLD
        push(16'h0009, 1'b1);
        chk("t6_in_fold", {31'd0, bus.in_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t6_rst_sum", {16'd0, bus.out_sum}, 32'h0000);
        chk("t6_rst_count", {16'd0, bus.out_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_result", {31'd0, bus.out_valid}, 32'd0);
        end

        // counter saturation on the CNTW=2 instance
        for (int k = 0; k < 5; k++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = 16'h0001;
            bus2.in_last  = (k == 4);
            @(negedge clk);
            if (k == 2) chk("t7_count3", {30'd0, bus2.out_count}, 32'd3);
            if (k == 3) chk("t7_count_sat", {30'd0, bus2.out_count}, 32'd3);
        end
        bus2.in_valid = 1'b0;
        bus2.in_last  = 1'b0;
        begin
            int n;
            n = 0;
            while (!bus2.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t7_valid", {31'd0, bus2.out_valid}, 32'd1);
        chk("t7_count", {30'd0, bus2.out_count}, 32'd3);
        chk("t7_sum", {16'd0, bus2.out_sum}, 32'h0005);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
